// File: rtl/myrr_prng_pkg.sv
// ============================================================================
//  Module   : myrr_prng_pkg
//  Purpose  : Shared constants and helpers for the multi-algorithm PRNG.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package myrr_prng_pkg;

  localparam logic PRNG_MODE_LCG  = 1'b0;
  localparam logic PRNG_MODE_LFSR = 1'b1;

  // Maximal-length Galois feedback masks for the common widths
  localparam logic [7:0]  PRNG_TAPS_W8  = 8'hB8;
  localparam logic [15:0] PRNG_TAPS_W16 = 16'hB400;
  localparam logic [31:0] PRNG_TAPS_W32 = 32'h80200003;

  function automatic logic [31:0] prng_default_taps(input int width);
    case (width)
      8:       return {24'h0, PRNG_TAPS_W8};
      16:      return {16'h0, PRNG_TAPS_W16};
      32:      return PRNG_TAPS_W32;
      default: return 32'h0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/myrr_prng_next.sv
// ============================================================================
//  Module   : myrr_prng_next
//  Purpose  : Combinational next-state function (LCG or Galois LFSR).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module myrr_prng_next import myrr_prng_pkg::*; #(
  parameter int               WIDTH = 16,
  parameter int               MULT  = 5,
  parameter int               INCR  = 1,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(prng_default_taps(WIDTH))
) (
  input  logic [WIDTH-1:0] i_state,
  input  logic             i_mode,
  output logic [WIDTH-1:0] o_next
);

  localparam int               c_PW   = 2 * WIDTH;
  localparam logic [c_PW-1:0]  c_MULT = c_PW'(MULT);
  localparam logic [c_PW-1:0]  c_INCR = c_PW'(INCR);
  localparam logic [WIDTH-1:0] c_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  if (MULT % 4 != 1) begin : g_bad_mult
    $error("myrr_prng_next: MULT must satisfy MULT %% 4 == 1");
  end
  if (INCR % 2 == 0) begin : g_bad_incr
    $error("myrr_prng_next: INCR must be odd");
  end

  logic [WIDTH-1:0] w_lcg;
  logic [WIDTH-1:0] w_lfsr;

  always_comb begin
    // Full double-width product, then the natural 2^WIDTH truncation
    w_lcg = WIDTH'(({{WIDTH{1'b0}}, i_state} * c_MULT) + c_INCR);
    if (i_state == '0) begin
      w_lfsr = c_ONE;
    end else begin
      w_lfsr = (i_state >> 1) ^ (i_state[0] ? TAPS : '0);
    end
    o_next = (i_mode == PRNG_MODE_LFSR) ? w_lfsr : w_lcg;
  end

endmodule

`default_nettype wire

// File: rtl/myrr_prng_multi.sv
// ============================================================================
//  Module   : myrr_prng_multi
//  Purpose  : Seeded PRNG with free-run/step advance and period measurement.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module myrr_prng_multi import myrr_prng_pkg::*; #(
  parameter int               WIDTH    = 16,
  parameter int               SEED_W   = 10,
  parameter int               SEED_LSB = 3,
  parameter int               MULT     = 5,
  parameter int               INCR     = 1,
  parameter logic [WIDTH-1:0] TAPS     = WIDTH'(prng_default_taps(WIDTH))
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic [SEED_W-1:0] Seed,
  input  logic              Load,
  input  logic              Enable,
  input  logic              Step,
  input  logic              Mode,
  output logic [WIDTH-1:0]  State,
  output logic [WIDTH-1:0]  Disp,
  output logic              Valid,
  output logic              Wrapped,
  output logic [WIDTH:0]    Period
);

  localparam logic [WIDTH:0] c_CNT_ONE = {{WIDTH{1'b0}}, 1'b1};

  if (WIDTH % 4 != 0) begin : g_bad_width
    $error("myrr_prng_multi: WIDTH must be a multiple of 4");
  end
  if (SEED_LSB + SEED_W > WIDTH) begin : g_bad_seed
    $error("myrr_prng_multi: seed field does not fit in WIDTH");
  end

  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] r_seed;
  logic [WIDTH:0]   r_count;
  logic [WIDTH:0]   r_period;
  logic             r_valid;
  logic             r_wrapped;

  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH:0]   w_count_inc;
  logic             w_advance;

  always_comb begin
    w_load_val                      = '0;
    w_load_val[SEED_LSB +: SEED_W]  = Seed;
    w_count_inc                     = r_count + c_CNT_ONE;
    w_advance                       = r_valid && !Load && (Enable || Step);
  end

  myrr_prng_next #(
    .WIDTH (WIDTH),
    .MULT  (MULT),
    .INCR  (INCR),
    .TAPS  (TAPS)
  ) u_next (
    .i_state (r_state),
    .i_mode  (Mode),
    .o_next  (w_next)
  );

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state   <= '0;
      r_seed    <= '0;
      r_count   <= '0;
      r_period  <= '0;
      r_valid   <= 1'b0;
      r_wrapped <= 1'b0;
    end else if (Load) begin
      r_state   <= w_load_val;
      r_seed    <= w_load_val;
      r_count   <= '0;
      r_valid   <= 1'b1;
      r_wrapped <= 1'b0;
    end else if (w_advance) begin
      r_state <= w_next;
      // Returning to the seed closes one cycle; the advance count is its period
      if (w_next == r_seed) begin
        r_wrapped <= 1'b1;
        r_period  <= w_count_inc;
        r_count   <= '0;
      end else begin
        r_wrapped <= 1'b0;
        r_count   <= w_count_inc;
      end
    end else begin
      r_wrapped <= 1'b0;
    end
  end

  for (genvar gi = 0; gi < WIDTH / 4; gi++) begin : g_disp
    assign Disp[4*gi +: 4] = r_state[4*gi +: 4];
  end

  assign State   = r_state;
  assign Valid   = r_valid;
  assign Wrapped = r_wrapped;
  assign Period  = r_period;

endmodule

`default_nettype wire

// File: tb/tb_myrr_prng_multi.sv
// ============================================================================
//  Module   : tb_myrr_prng_multi
//  Purpose  : Self-checking bench for myrr_prng_multi (16-bit and 8-bit builds).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_myrr_prng_multi;

  logic        r_clk;
  logic        r_rst_n;

  logic [9:0]  r_a_seed;
  logic        r_a_load, r_a_en, r_a_step, r_a_mode;
  logic [15:0] w_a_state, w_a_disp;
  logic        w_a_valid, w_a_wr;
  logic [16:0] w_a_per;

  logic [3:0]  r_b_seed;
  logic        r_b_load, r_b_en, r_b_step, r_b_mode;
  logic [7:0]  w_b_state, w_b_disp;
  logic        w_b_valid, w_b_wr;
  logic [8:0]  w_b_per;

  int total = 0;
  int bad   = 0;

  myrr_prng_multi u_dut16 (
    .Clock(r_clk), .Reset_n(r_rst_n), .Seed(r_a_seed), .Load(r_a_load),
    .Enable(r_a_en), .Step(r_a_step), .Mode(r_a_mode), .State(w_a_state),
    .Disp(w_a_disp), .Valid(w_a_valid), .Wrapped(w_a_wr), .Period(w_a_per)
  );

  myrr_prng_multi #(
    .WIDTH(8), .SEED_W(4), .SEED_LSB(0), .MULT(5), .INCR(1), .TAPS(8'hB8)
  ) u_dut8 (
    .Clock(r_clk), .Reset_n(r_rst_n), .Seed(r_b_seed), .Load(r_b_load),
    .Enable(r_b_en), .Step(r_b_step), .Mode(r_b_mode), .State(w_b_state),
    .Disp(w_b_disp), .Valid(w_b_valid), .Wrapped(w_b_wr), .Period(w_b_per)
  );

  initial r_clk = 1'b0;
  always #5 r_clk = ~r_clk;

  // Behavioural model: plain integer arithmetic on the generator rules
  typedef struct {
    longint st;
    longint sd;
    longint cnt;
    longint per;
    bit     val;
    bit     wr;
  } mdl_t;

  mdl_t ma, mb;

  function automatic longint mnext(int w, bit md, longint s, longint taps);
    if (md) begin
      if (s == 0) return 1;
      return (s / 2) ^ ((s % 2 == 1) ? taps : 0);
    end
    return (s * 5 + 1) % (longint'(1) << w);
  endfunction

  function automatic mdl_t mupd(int w, int lsb, int seedw, longint taps,
                                bit ld, bit en, bit stp, bit md, longint seed, mdl_t m);
    mdl_t r = m;
    longint n;
    if (ld) begin
      r.st  = (seed % (longint'(1) << seedw)) * (longint'(1) << lsb);
      r.sd  = r.st;
      r.cnt = 0;
      r.val = 1'b1;
      r.wr  = 1'b0;
    end else if (m.val && (en || stp)) begin
      n     = mnext(w, md, m.st, taps);
      r.cnt = (m.cnt + 1) % (longint'(1) << (w + 1));
      if (n == m.sd) begin
        r.wr  = 1'b1;
        r.per = r.cnt;
        r.cnt = 0;
      end else begin
        r.wr = 1'b0;
      end
      r.st = n;
    end else begin
      r.wr = 1'b0;
    end
    return r;
  endfunction

  function automatic mdl_t mreset();
    mdl_t r;
    r.st = 0; r.sd = 0; r.cnt = 0; r.per = 0; r.val = 1'b0; r.wr = 1'b0;
    return r;
  endfunction

  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance both models with the inputs currently applied, then sample after the edge
  task automatic tick();
    ma = mupd(16, 3, 10, 64'hB400, r_a_load, r_a_en, r_a_step, r_a_mode, longint'(r_a_seed), ma);
    mb = mupd(8, 0, 4, 64'hB8, r_b_load, r_b_en, r_b_step, r_b_mode, longint'(r_b_seed), mb);
    @(posedge r_clk);
    #1;
  endtask

  task automatic chk_all(input string tag);
    check({tag, ".a_state"}, longint'(w_a_state), ma.st);
    check({tag, ".a_disp"},  longint'(w_a_disp),  ma.st);
    check({tag, ".a_valid"}, longint'(w_a_valid), longint'(ma.val));
    check({tag, ".a_wrap"},  longint'(w_a_wr),    longint'(ma.wr));
    check({tag, ".a_per"},   longint'(w_a_per),   ma.per);
    check({tag, ".b_state"}, longint'(w_b_state), mb.st);
    check({tag, ".b_disp"},  longint'(w_b_disp),  mb.st);
    check({tag, ".b_valid"}, longint'(w_b_valid), longint'(mb.val));
    check({tag, ".b_wrap"},  longint'(w_b_wr),    longint'(mb.wr));
    check({tag, ".b_per"},   longint'(w_b_per),   mb.per);
  endtask

  typedef struct {
    bit          ld;
    bit          en;
    bit          st;
    bit          md;
    logic [9:0]  seed;
    logic [15:0] exp_state;
    bit          exp_wr;
    bit          exp_val;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int pulses;

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 10'h001, 16'h0008, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 10'h000, 16'h0029, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 10'h000, 16'h00CE, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 16'h00CE, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 10'h001, 16'h0008, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 10'h000, 16'h0004, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 10'h000, 16'h0000, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 10'h000, 16'h0001, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 10'h000, 16'hB400, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 10'h002, 16'h0010, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 16'h0051, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 10'h000, 16'h0196, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 10'h000, 16'h0196, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 10'h000, 16'h00CB, 1'b0, 1'b1};

    r_rst_n  = 1'b0;
    r_a_seed = '0; r_a_load = 0; r_a_en = 0; r_a_step = 0; r_a_mode = 0;
    r_b_seed = '0; r_b_load = 0; r_b_en = 0; r_b_step = 0; r_b_mode = 0;
    ma = mreset();
    mb = mreset();
    @(posedge r_clk);
    #1;
    check("reset.a_state", longint'(w_a_state), 0);
    check("reset.a_valid", longint'(w_a_valid), 0);
    check("reset.a_per",   longint'(w_a_per),   0);
    check("reset.b_wrap",  longint'(w_b_wr),    0);
    r_rst_n = 1'b1;

    // Unseeded generator ignores Enable
    r_a_en = 1'b1;
    r_b_en = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("hold.a_state", longint'(w_a_state), 0);
      check("hold.a_valid", longint'(w_a_valid), 0);
      chk_all("hold");
    end
    r_a_en = 1'b0;
    r_b_en = 1'b0;

    for (int i = 0; i < 14; i++) begin
      r_a_load = tbl[i].ld;
      r_a_en   = tbl[i].en;
      r_a_step = tbl[i].st;
      r_a_mode = tbl[i].md;
      r_a_seed = tbl[i].seed;
      tick();
      check($sformatf("vec%0d.state", i), longint'(w_a_state), longint'(tbl[i].exp_state));
      check($sformatf("vec%0d.disp", i),  longint'(w_a_disp),  longint'(tbl[i].exp_state));
      check($sformatf("vec%0d.wrap", i),  longint'(w_a_wr),    longint'(tbl[i].exp_wr));
      check($sformatf("vec%0d.valid", i), longint'(w_a_valid), longint'(tbl[i].exp_val));
    end
    r_a_load = 0; r_a_en = 0; r_a_step = 0; r_a_mode = 0;

    // Full-period LCG run on the 8-bit build
    r_b_seed = 4'h3; r_b_load = 1'b1; r_b_mode = 1'b0;
    tick();
    check("wrap.load", longint'(w_b_state), 3);
    r_b_load = 1'b0;
    r_b_en   = 1'b1;
    pulses   = 0;
    for (int c = 1; c <= 512; c++) begin
      tick();
      check("wrap.state", longint'(w_b_state), mb.st);
      if (w_b_wr) begin
        pulses++;
        check("wrap.pos", longint'(c), longint'(pulses * 256));
      end
    end
    check("wrap.pulses", longint'(pulses), 2);
    check("wrap.period", longint'(w_b_per), 256);

    for (int c = 0; c < 3000; c++) begin
      r_a_load = ($urandom_range(0, 63) == 0);
      r_a_en   = ($urandom_range(0, 2) == 0);
      r_a_step = ($urandom_range(0, 3) == 0);
      r_a_mode = 1'($urandom_range(0, 1));
      r_a_seed = 10'($urandom);
      r_b_load = ($urandom_range(0, 399) == 0);
      r_b_en   = ($urandom_range(0, 9) != 0);
      r_b_step = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 99) == 0) r_b_mode = ~r_b_mode;
      r_b_seed = 4'($urandom);
      tick();
      chk_all("rand");
    end

    // Asynchronous reset between edges discards everything
    r_a_load = 1'b1; r_a_seed = 10'h05A; r_b_load = 1'b1; r_b_seed = 4'h5;
    tick();
    r_a_load = 1'b0; r_b_load = 1'b0; r_a_en = 1'b1; r_b_en = 1'b1; r_b_mode = 1'b0;
    for (int c = 0; c < 300; c++) tick();
    chk_all("prerst");
    #2;
    r_rst_n = 1'b0;
    #1;
    ma = mreset();
    mb = mreset();
    check("arst.a_state", longint'(w_a_state), 0);
    check("arst.a_valid", longint'(w_a_valid), 0);
    check("arst.b_state", longint'(w_b_state), 0);
    check("arst.b_per",   longint'(w_b_per),   0);
    check("arst.b_valid", longint'(w_b_valid), 0);
    #1;
    r_rst_n = 1'b1;
    for (int c = 0; c < 300; c++) begin
      tick();
      check("postrst.b_wrap",  longint'(w_b_wr),    0);
      check("postrst.b_state", longint'(w_b_state), 0);
      chk_all("postrst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
